regfile_rs_mp: RTL and testbench
================================

# regfile_rs_mp

Parametrised successor to the single-issue Tomasulo register file. It holds architectural register values plus a per-register status tag naming the reservation station that will produce each value. It adds N read ports with same-cycle CDB bypass, M simultaneous CDB channels, and a flush that clears all pending tags. It sits between issue logic (source reads and destination rename) and the common data buses (result writeback).

## Interface
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired to zero.
- NUM_RD, 4, number of read ports.
- NUM_CDB, 2, number of CDB channels broadcasting per cycle.
- XLEN, 32, data width.
- clk_i  in  1  clock, all state updates on rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- cdb_i  in  NUM_CDB x cdb_t  per-channel {tag, val}; tag == NO_VAL means the channel is idle.
- rd_addr_i  in  NUM_RD x $clog2(NUM_REGS)  read addresses.
- rd_data_o  out  NUM_RD x XLEN  read value (bypassed if applicable).
- rd_tag_o  out  NUM_RD x rs_tag_t  pending producer tag; NO_VAL if the value is ready.
- rd_ready_o  out  NUM_RD x 1  1 when rd_tag_o == NO_VAL.
- ren_en_i  in  1  rename (issue) write enable.
- ren_idx_i  in  $clog2(NUM_REGS)  destination register.
- ren_tag_i  in  rs_tag_t  tag to assign.
- flush_i  in  1  clear all status tags.

## Operation
- State: registers[NUM_REGS] (XLEN), reg_status[NUM_REGS] (rs_tag_t).
- Read, per port p, combinational:
  - addr 0 -> data 0, tag NO_VAL, ready 1.
  - Else, if reg_status[addr] != NO_VAL and it equals some cdb_i[k].tag (k lowest matching) -> data = cdb_i[k].val, tag NO_VAL, ready 1 (bypass).
  - Else -> registers[addr], reg_status[addr].
- Reads ignore a same-cycle rename and return the pre-rename status, so an instruction reading rd as a source while renaming rd sees the old producer.
- CDB writeback, per register r != 0:
  - Match when reg_status[r] != NO_VAL and reg_status[r] == cdb_i[k].tag.
  - On match: registers[r] <= cdb_i[k].val and reg_status[r] <= NO_VAL.
  - A CDB tag of NO_VAL never matches, so reset or idle tags never cause writes.
- Rename: if ren_en_i and ren_idx_i != 0, reg_status[ren_idx_i] <= ren_tag_i.
- Rename/CDB collision on the same register in the same cycle: the data write still happens and the status takes ren_tag_i (issue wins).
- ren_idx_i == 0 is ignored; register 0 and its status never change.
- Flush: all reg_status <= NO_VAL.
  - Flush overrides rename and CDB status clears.
  - CDB data writes matching the pre-flush tags still occur.
- Two CDB channels carrying the same non-NO_VAL tag is illegal. An assertion flags it; the lowest channel index wins.
- ren_tag_i == NO_VAL with ren_en_i is legal and marks the register ready.

## Timing
- Reset (reset_ni low, asynchronous assert, synchronous release): all registers 0, all reg_status NO_VAL.
  - Outputs during reset: rd_data_o 0, rd_tag_o NO_VAL, rd_ready_o 1.
- Read latency: 0 cycles (combinational from rd_addr_i, state and cdb_i).
- CDB to register visible without bypass: 1 edge. Bypass makes the value visible in the broadcast cycle itself.
- Rename visible on rd_tag_o: the cycle after the edge that samples ren_en_i.
- Flush takes effect at the next edge; reads in the flush cycle still show old tags.
- Reset asserted mid-operation discards all pending tags and values immediately.

## Structure
- data_types additions: cdb_t (already present), REGFILE_SIZE used as the NUM_REGS default, NO_VAL, rs_tag_t, and a cdb_vec_t packed-array alias for NUM_CDB.
- Sub-module cdb_match: combinational. Takes a tag plus cdb_i and returns {hit, val}. Instantiated once per register (writeback) and once per read port (bypass).
- Top level holds the state arrays, the priority logic (flush > rename > CDB clear) and the read muxes.

## Test plan
- Reset, then read all 32 registers across 4 ports -> data 0, tag NO_VAL, ready 1. Drive cdb_i[0] = {NO_VAL, FEEF_FEEF} -> no register changes.
- Rename x10 <- ALU_1. Next cycle read x10 -> tag ALU_1, ready 0. Broadcast {ALU_1, CAFE_CAFE} on cdb_i[1] -> same-cycle read gives CAFE_CAFE, ready 1. After the edge, registers[10] = CAFE_CAFE and status NO_VAL.
- Rename x20 <- SHIFT_1. Then in one cycle broadcast {SHIFT_1, BEEB_BABA} and rename x20 <- ALU_2 -> registers[20] = BEEB_BABA, status ALU_2.
- Rename x1 <- ALU_1 and x2 <- ALU_2. Broadcast both on cdb_i[0] and cdb_i[1] in one cycle -> x1 = 1111_1111 and x2 = 2222_2222, both ready.
- Rename x0 <- ALU_1 and broadcast {ALU_1, FFFF_FFFF} -> x0 reads 0, NO_VAL.
- Rename x5 <- ALU_1, then assert flush_i -> x5 status NO_VAL, value unchanged. A later {ALU_1, 1234_5678} leaves x5 unchanged.
- Pull reset_ni low mid-sequence between clock edges -> registers and tags clear immediately.

Source files
------------

// File: rtl/regfile_rs_mp_pkg.sv
// Shared types for the multi-port Tomasulo register file: reservation
// station tags, the CDB broadcast record and sizing constants.
package regfile_rs_mp_pkg;

   localparam int REGFILE_SIZE = 32;
   localparam int DATA_W       = 32;
   localparam int NUM_CDB_DEF  = 2;

   // Tag 0 is reserved to mean "no producer pending / value ready".
   typedef enum logic [2:0] {
      NO_VAL  = 3'd0,
      ALU_1   = 3'd1,
      ALU_2   = 3'd2,
      ALU_3   = 3'd3,
      SHIFT_1 = 3'd4,
      SHIFT_2 = 3'd5,
      MEM_1   = 3'd6,
      MEM_2   = 3'd7
   } rs_tag_t;

   typedef struct packed {
      rs_tag_t           tag;
      logic [DATA_W-1:0] val;
   } cdb_t;

   typedef cdb_t [NUM_CDB_DEF-1:0] cdb_vec_t;

   // A tag names a real producer only when it is not the idle marker.
   function automatic logic tag_pending(input rs_tag_t t);
      return t != NO_VAL;
   endfunction

endpackage

// File: rtl/regfile_rs_mp_cdb_match.sv
// Combinational CDB lookup: reports whether any channel broadcasts the
// given tag and returns that channel's value. Lowest channel index wins.
module cdb_match
   import regfile_rs_mp_pkg::*;
#(
   parameter int NUM_CDB = NUM_CDB_DEF
) (
   input  rs_tag_t                 tag_i,
   input  cdb_t [NUM_CDB-1:0]      cdb_i,
   output logic                    hit_o,
   output logic [DATA_W-1:0]       val_o
);

   // Scan from the highest channel down so the lowest matching one is left.
   always_comb begin
      // NOTE: every output gets a default first so no path through this block infers a latch.
      hit_o = 1'b0;
      val_o = '0;
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
         if (tag_pending(tag_i) && (cdb_i[k].tag == tag_i)) begin
            hit_o = 1'b1;
            val_o = cdb_i[k].val;
         end
      end
   end

endmodule

// File: rtl/regfile_rs_mp.sv
// Register file with per-register producer tags, NUM_RD bypassed read
// ports, NUM_CDB writeback channels, single rename port and tag flush.
module regfile_rs_mp
   import regfile_rs_mp_pkg::*;
#(
   parameter int NUM_REGS = REGFILE_SIZE,
   parameter int NUM_RD   = 4,
   parameter int NUM_CDB  = NUM_CDB_DEF,
   parameter int XLEN     = DATA_W,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic                           clk_i,
   input  logic                           reset_ni,
   input  cdb_t [NUM_CDB-1:0]             cdb_i,
   input  logic [NUM_RD-1:0][AW-1:0]      rd_addr_i,
   output logic [NUM_RD-1:0][XLEN-1:0]    rd_data_o,
   output rs_tag_t [NUM_RD-1:0]           rd_tag_o,
   output logic [NUM_RD-1:0]              rd_ready_o,
   input  logic                           ren_en_i,
   input  logic [AW-1:0]                  ren_idx_i,
   input  rs_tag_t                        ren_tag_i,
   input  logic                           flush_i
);

   logic [XLEN-1:0] registers  [NUM_REGS];
   rs_tag_t         reg_status [NUM_REGS];

   logic [NUM_REGS-1:0] wb_hit;
   logic [XLEN-1:0]     wb_val [NUM_REGS];

   rs_tag_t             rd_status [NUM_RD];
   logic [NUM_RD-1:0]   byp_hit;
   logic [XLEN-1:0]     byp_val   [NUM_RD];

   logic                dup_tag;

   // One matcher per register decides whether this cycle's CDB retires it.
   for (genvar r = 0; r < NUM_REGS; r++) begin : g_wb
      cdb_match #(.NUM_CDB(NUM_CDB)) u_wb_match (
         .tag_i (reg_status[r]),
         .cdb_i (cdb_i),
         .hit_o (wb_hit[r]),
         .val_o (wb_val[r])
      );
   end

   // One matcher per read port forwards a value broadcast this very cycle.
   for (genvar p = 0; p < NUM_RD; p++) begin : g_byp
      assign rd_status[p] = reg_status[rd_addr_i[p]];

      cdb_match #(.NUM_CDB(NUM_CDB)) u_byp_match (
         .tag_i (rd_status[p]),
         .cdb_i (cdb_i),
         .hit_o (byp_hit[p]),
         .val_o (byp_val[p])
      );
   end

   // State update: data follows CDB hits; status priority is flush > rename > CDB clear.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         // NOTE: the whole array is reset because a reset must drop every pending tag and value at once.
         for (int r = 0; r < NUM_REGS; r++) begin
            registers[r]  <= '0;
            reg_status[r] <= NO_VAL;
         end
      end else begin
         // Register 0 is never written, so it stays at its reset value of zero.
         for (int r = 1; r < NUM_REGS; r++) begin
            // NOTE: non-blocking writes so every register sees the pre-edge status in this loop.
            if (wb_hit[r]) begin
               registers[r] <= wb_val[r];
            end
            if (flush_i) begin
               reg_status[r] <= NO_VAL;
            end else if (ren_en_i && (ren_idx_i == AW'(r))) begin
               reg_status[r] <= ren_tag_i;
            end else if (wb_hit[r]) begin
               reg_status[r] <= NO_VAL;
            end
         end
      end
   end

   // Read muxes: x0 is constant zero, a same-cycle CDB hit is forwarded, else the stored state.
   always_comb begin
      for (int p = 0; p < NUM_RD; p++) begin
         rd_data_o[p]  = '0;
         rd_tag_o[p]   = NO_VAL;
         rd_ready_o[p] = 1'b1;
         if (rd_addr_i[p] != '0) begin
            if (byp_hit[p]) begin
               rd_data_o[p] = byp_val[p];
            end else begin
               rd_data_o[p]  = registers[rd_addr_i[p]];
               rd_tag_o[p]   = rd_status[p];
               rd_ready_o[p] = !tag_pending(rd_status[p]);
            end
         end
      end
   end

   // Two live channels carrying one tag means two producers claim the same station.
   always_comb begin
      dup_tag = 1'b0;
      for (int i = 0; i < NUM_CDB; i++) begin
         for (int j = i + 1; j < NUM_CDB; j++) begin
            if (tag_pending(cdb_i[i].tag) && (cdb_i[i].tag == cdb_i[j].tag)) begin
               dup_tag = 1'b1;
            end
         end
      end
   end

   a_no_dup_cdb_tag : assert property (@(posedge clk_i) disable iff (!reset_ni) !dup_tag);

endmodule

// File: tb/tb_regfile_rs_mp.sv
// Directed bench for regfile_rs_mp: reset, rename, bypass, collisions,
// dual-channel writeback, x0 protection, flush and asynchronous reset.
module tb_regfile_rs_mp;
   import regfile_rs_mp_pkg::*;

   localparam int NUM_REGS = 32;
   localparam int NUM_RD   = 4;
   localparam int NUM_CDB  = 2;
   localparam int XLEN     = 32;
   localparam int AW       = 5;

   logic                        clk;
   logic                        reset_ni;
   cdb_vec_t                    cdb;
   logic [NUM_RD-1:0][AW-1:0]   rd_addr;
   logic [NUM_RD-1:0][XLEN-1:0] rd_data;
   rs_tag_t [NUM_RD-1:0]        rd_tag;
   logic [NUM_RD-1:0]           rd_ready;
   logic                        ren_en;
   logic [AW-1:0]               ren_idx;
   rs_tag_t                     ren_tag;
   logic                        flush;

   int checks;
   int errors;

   regfile_rs_mp #(
      .NUM_REGS (NUM_REGS),
      .NUM_RD   (NUM_RD),
      .NUM_CDB  (NUM_CDB),
      .XLEN     (XLEN)
   ) dut (
      .clk_i      (clk),
      .reset_ni   (reset_ni),
      .cdb_i      (cdb),
      .rd_addr_i  (rd_addr),
      .rd_data_o  (rd_data),
      .rd_tag_o   (rd_tag),
      .rd_ready_o (rd_ready),
      .ren_en_i   (ren_en),
      .ren_idx_i  (ren_idx),
      .ren_tag_i  (ren_tag),
      .flush_i    (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reset state, full read sweep, and an idle-tag broadcast that must not write.
   task automatic test_reset();
      rd_addr = {5'd31, 5'd20, 5'd10, 5'd3};
      #2;
      for (int p = 0; p < NUM_RD; p++) begin
         checks++;
         if (rd_data[p] !== '0 || rd_tag[p] !== NO_VAL || rd_ready[p] !== 1'b1) begin
            errors++;
            $display("FAIL in_reset port %0d: data=%h tag=%0d ready=%b, want 0/0/1",
                     p, rd_data[p], rd_tag[p], rd_ready[p]);
         end
      end
      @(negedge clk);
      reset_ni = 1'b1;
      for (int g = 0; g < NUM_REGS / NUM_RD; g++) begin
         for (int p = 0; p < NUM_RD; p++) rd_addr[p] = AW'(g * NUM_RD + p);
         #1;
         for (int p = 0; p < NUM_RD; p++) begin
            checks++;
            if (rd_data[p] !== '0 || rd_tag[p] !== NO_VAL || rd_ready[p] !== 1'b1) begin
               errors++;
               $display("FAIL post_reset x%0d: data=%h tag=%0d ready=%b, want 0/0/1",
                        g * NUM_RD + p, rd_data[p], rd_tag[p], rd_ready[p]);
            end
         end
      end
      @(negedge clk);
      cdb[0] = '{tag: NO_VAL, val: 32'hFEEF_FEEF};
      @(negedge clk);
      cdb = '0;
      for (int g = 0; g < NUM_REGS / NUM_RD; g++) begin
         for (int p = 0; p < NUM_RD; p++) rd_addr[p] = AW'(g * NUM_RD + p);
         #1;
         for (int p = 0; p < NUM_RD; p++) begin
            checks++;
            if (rd_data[p] !== '0 || rd_tag[p] !== NO_VAL) begin
               errors++;
               $display("FAIL idle_cdb x%0d: data=%h tag=%0d, want 0/0",
                        g * NUM_RD + p, rd_data[p], rd_tag[p]);
            end
         end
      end
   endtask

   // Rename x10, observe pending, bypass from channel 1, then committed value.
   task automatic test_rename_bypass();
      @(negedge clk);
      ren_en = 1'b1; ren_idx = 5'd10; ren_tag = ALU_1;
      rd_addr[0] = 5'd10;
      #1;
      checks++;
      if (rd_tag[0] !== NO_VAL || rd_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL rename_same_cycle: tag=%0d ready=%b, want 0/1", rd_tag[0], rd_ready[0]);
      end
      @(negedge clk);
      ren_en = 1'b0;
      #1;
      checks++;
      if (rd_tag[0] !== ALU_1 || rd_ready[0] !== 1'b0 || rd_data[0] !== '0) begin
         errors++;
         $display("FAIL rename_visible: tag=%0d ready=%b data=%h, want %0d/0/0",
                  rd_tag[0], rd_ready[0], rd_data[0], ALU_1);
      end
      cdb[1] = '{tag: ALU_1, val: 32'hCAFE_CAFE};
      #1;
      checks++;
      if (rd_data[0] !== 32'hCAFE_CAFE || rd_tag[0] !== NO_VAL || rd_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL bypass: data=%h tag=%0d ready=%b, want cafecafe/0/1",
                  rd_data[0], rd_tag[0], rd_ready[0]);
      end
      @(negedge clk);
      cdb = '0;
      #1;
      checks++;
      if (rd_data[0] !== 32'hCAFE_CAFE || rd_tag[0] !== NO_VAL || rd_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL writeback_x10: data=%h tag=%0d ready=%b, want cafecafe/0/1",
                  rd_data[0], rd_tag[0], rd_ready[0]);
      end
   endtask

   // Same-cycle CDB write and rename on x20: data lands, rename tag wins.
   task automatic test_collision();
      @(negedge clk);
      ren_en = 1'b1; ren_idx = 5'd20; ren_tag = SHIFT_1;
      @(negedge clk);
      ren_tag = ALU_2;
      cdb[0] = '{tag: SHIFT_1, val: 32'hBEEB_BABA};
      @(negedge clk);
      ren_en = 1'b0;
      cdb = '0;
      rd_addr[1] = 5'd20;
      #1;
      checks++;
      if (rd_data[1] !== 32'hBEEB_BABA || rd_tag[1] !== ALU_2 || rd_ready[1] !== 1'b0) begin
         errors++;
         $display("FAIL collision_x20: data=%h tag=%0d ready=%b, want beebbaba/%0d/0",
                  rd_data[1], rd_tag[1], rd_ready[1], ALU_2);
      end
   endtask

   // Both channels retire different tags in one cycle; ALU_2 also retires x20.
   task automatic test_dual_cdb();
      @(negedge clk);
      ren_en = 1'b1; ren_idx = 5'd1; ren_tag = ALU_1;
      @(negedge clk);
      ren_idx = 5'd2; ren_tag = ALU_2;
      @(negedge clk);
      ren_en = 1'b0;
      cdb[0] = '{tag: ALU_1, val: 32'h1111_1111};
      cdb[1] = '{tag: ALU_2, val: 32'h2222_2222};
      @(negedge clk);
      cdb = '0;
      rd_addr = {5'd0, 5'd20, 5'd2, 5'd1};
      #1;
      checks++;
      if (rd_data[0] !== 32'h1111_1111 || rd_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL dual_x1: data=%h ready=%b, want 11111111/1", rd_data[0], rd_ready[0]);
      end
      checks++;
      if (rd_data[1] !== 32'h2222_2222 || rd_ready[1] !== 1'b1) begin
         errors++;
         $display("FAIL dual_x2: data=%h ready=%b, want 22222222/1", rd_data[1], rd_ready[1]);
      end
      checks++;
      if (rd_data[2] !== 32'h2222_2222 || rd_tag[2] !== NO_VAL) begin
         errors++;
         $display("FAIL dual_x20: data=%h tag=%0d, want 22222222/0", rd_data[2], rd_tag[2]);
      end
   endtask

   // Renames and broadcasts aimed at x0 leave it zero and ready.
   task automatic test_x0();
      @(negedge clk);
      ren_en = 1'b1; ren_idx = 5'd0; ren_tag = ALU_1;
      @(negedge clk);
      ren_en = 1'b0;
      rd_addr[3] = 5'd0;
      cdb[0] = '{tag: ALU_1, val: 32'hFFFF_FFFF};
      #1;
      checks++;
      if (rd_data[3] !== '0 || rd_tag[3] !== NO_VAL || rd_ready[3] !== 1'b1) begin
         errors++;
         $display("FAIL x0_bypass: data=%h tag=%0d ready=%b, want 0/0/1",
                  rd_data[3], rd_tag[3], rd_ready[3]);
      end
      @(negedge clk);
      cdb = '0;
      #1;
      checks++;
      if (rd_data[3] !== '0 || rd_tag[3] !== NO_VAL) begin
         errors++;
         $display("FAIL x0_after: data=%h tag=%0d, want 0/0", rd_data[3], rd_tag[3]);
      end
   endtask

   // Flush clears tags next edge, beats rename, and still lets matched data land.
   task automatic test_flush();
      @(negedge clk);
      ren_en = 1'b1; ren_idx = 5'd5; ren_tag = ALU_1;
      rd_addr[0] = 5'd5;
      @(negedge clk);
      ren_en = 1'b0;
      flush  = 1'b1;
      #1;
      checks++;
      if (rd_tag[0] !== ALU_1) begin
         errors++;
         $display("FAIL flush_cycle_tag: tag=%0d, want %0d", rd_tag[0], ALU_1);
      end
      @(negedge clk);
      flush = 1'b0;
      #1;
      checks++;
      if (rd_tag[0] !== NO_VAL || rd_ready[0] !== 1'b1 || rd_data[0] !== '0) begin
         errors++;
         $display("FAIL flush_x5: tag=%0d ready=%b data=%h, want 0/1/0",
                  rd_tag[0], rd_ready[0], rd_data[0]);
      end
      cdb[0] = '{tag: ALU_1, val: 32'h1234_5678};
      @(negedge clk);
      cdb = '0;
      #1;
      checks++;
      if (rd_data[0] !== '0) begin
         errors++;
         $display("FAIL stale_cdb_x5: data=%h, want 0", rd_data[0]);
      end
      ren_en = 1'b1; ren_idx = 5'd6; ren_tag = ALU_3;
      @(negedge clk);
      ren_idx = 5'd7;
      flush   = 1'b1;
      cdb[0]  = '{tag: ALU_3, val: 32'hAAAA_5555};
      @(negedge clk);
      ren_en = 1'b0;
      flush  = 1'b0;
      cdb    = '0;
      rd_addr[1] = 5'd6;
      rd_addr[2] = 5'd7;
      #1;
      checks++;
      if (rd_data[1] !== 32'hAAAA_5555 || rd_tag[1] !== NO_VAL) begin
         errors++;
         $display("FAIL flush_data_x6: data=%h tag=%0d, want aaaa5555/0", rd_data[1], rd_tag[1]);
      end
      checks++;
      if (rd_tag[2] !== NO_VAL || rd_ready[2] !== 1'b1) begin
         errors++;
         $display("FAIL flush_over_rename_x7: tag=%0d ready=%b, want 0/1", rd_tag[2], rd_ready[2]);
      end
   endtask

   // Reset pulled low between edges clears values and tags without a clock.
   task automatic test_async_reset();
      @(negedge clk);
      ren_en = 1'b1; ren_idx = 5'd8; ren_tag = MEM_1;
      @(negedge clk);
      ren_en = 1'b0;
      rd_addr = {5'd6, 5'd1, 5'd8, 5'd10};
      #1;
      checks++;
      if (rd_tag[1] !== MEM_1 || rd_data[0] !== 32'hCAFE_CAFE) begin
         errors++;
         $display("FAIL pre_reset: x8 tag=%0d x10 data=%h, want %0d/cafecafe",
                  rd_tag[1], rd_data[0], MEM_1);
      end
      #1;
      reset_ni = 1'b0;
      #1;
      for (int p = 0; p < NUM_RD; p++) begin
         checks++;
         if (rd_data[p] !== '0 || rd_tag[p] !== NO_VAL || rd_ready[p] !== 1'b1) begin
            errors++;
            $display("FAIL async_reset port %0d: data=%h tag=%0d ready=%b, want 0/0/1",
                     p, rd_data[p], rd_tag[p], rd_ready[p]);
         end
      end
      @(negedge clk);
      reset_ni = 1'b1;
      @(negedge clk);
      checks++;
      if (rd_tag[1] !== NO_VAL || rd_data[0] !== '0) begin
         errors++;
         $display("FAIL after_release: x8 tag=%0d x10 data=%h, want 0/0", rd_tag[1], rd_data[0]);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset_ni = 1'b0;
      cdb      = '0;
      rd_addr  = '0;
      ren_en   = 1'b0;
      ren_idx  = '0;
      ren_tag  = NO_VAL;
      flush    = 1'b0;

      test_reset();
      test_rename_bypass();
      test_collision();
      test_dual_cdb();
      test_x0();
      test_flush();
      test_async_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
